cordic_vector: RTL and testbench
================================

CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 The block SHALL have parameter DW, default 9, meaning input coordinate width (two's complement).
REQ-002 The block SHALL have parameter ITER, default 8, meaning number of micro-rotations, fixed at 8 to match the arctangent table.
REQ-003 Port clock  input  1  rising-edge clock for all state.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request to begin a conversion, sampled on rising edges.
REQ-006 Port x_in  input  DW  signed X coordinate, sampled only on the accepting edge.
REQ-007 Port y_in  input  DW  signed Y coordinate, sampled only on the accepting edge.
REQ-008 Port busy  output  1  high while a conversion is in progress.
REQ-009 Port done  output  1  one-cycle pulse marking new results.
REQ-010 Port mag  output  DW+1  unsigned magnitude scaled by CORDIC gain K (about 1.6468).
REQ-011 Port angle  output  DW  signed angle, LSB = pi/256 rad, range -256..255 (-pi..pi).

Function
REQ-012 Reset is "reset, synchronous, active-high; clock clock"; all state SHALL be driven from clock.
REQ-013 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 In IDLE, start=1 SHALL be accepted on that edge: capture x_in/y_in, apply pre-rotation, clear the iteration counter and enter RUN.
REQ-015 start SHALL be ignored in RUN; x_in/y_in SHALL be don't-care outside the accepting edge.
REQ-016 Pre-rotation: x_in>=0 -> (x,y,z)=(x_in,y_in,0); x_in<0 and y_in>=0 -> (y_in,-x_in,+128); x_in<0 and y_in<0 -> (-y_in,x_in,-128).
REQ-017 The internal x and y registers SHALL be DW+2 bits signed so that negating -256 and applying gain never overflow; z SHALL be DW+1 bits signed.
REQ-018 Iteration i (0..7), one per clock: if y>=0 then x+=y>>>i, y-=x>>>i, z+=A[i]; else x-=y>>>i, y+=x>>>i, z-=A[i]; the shifts are arithmetic and use the old values of x and y.
REQ-019 The arctangent table A[0..7] SHALL be 64, 38, 20, 10, 5, 3, 1, 1 (pi/256 units).
REQ-020 Latency: if start is accepted at edge N, iterations SHALL occur at edges N+1..N+8, and at edge N+8 mag, angle and done=1 SHALL update, busy SHALL fall and the FSM SHALL return to IDLE.
REQ-021 done SHALL be high for exactly one cycle per completed conversion.
REQ-022 A new start in the same cycle that done is high SHALL be accepted, allowing back-to-back conversions every 9 cycles.
REQ-023 mag SHALL be final x[DW:0], which is non-negative by construction; no gain compensation is applied.
REQ-024 angle SHALL be final z[DW-1:0], taken modulo 512, so +pi wraps to -256.
REQ-025 A zero vector input (x_in=0, y_in=0) SHALL produce mag=0 and angle=0 at the normal latency.
REQ-026 mag and angle SHALL hold their values between completions.

Reset
REQ-027 When reset=1, the block SHALL force the FSM to IDLE and set busy=0, done=0, mag=0, angle=0, and x, y, z and the counter to 0.
REQ-028 Reset SHALL take priority over start and SHALL abort an in-progress conversion with no done pulse.
REQ-029 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-030 Start with (100,0) -> done exactly 8 cycles after acceptance; mag in 163..166; angle in -2..2.
REQ-031 Start with (0,100) -> mag in 163..166; angle in 126..130.
REQ-032 Start with (-100,-100) -> mag in 230..236; angle in -194..-190. Start with (-256,0) -> mag in 419..424; angle in {254,255,-256,-255,-254}.
REQ-033 Start with (0,0) -> mag=0, angle=0, and done after 8 cycles.
REQ-034 Pulse start again at cycle 3 of a conversion -> it is ignored, with one done and results from the first operands; start held during the done cycle -> second result 9 cycles after the first.
REQ-035 Assert reset at iteration 4 -> next cycle busy=0, done=0, mag=0, angle=0, and no done follows; then start (100,0) -> correct result per REQ-030.

Source files
------------

// File: rtl/cordic_vector.sv
// cordic_vector: iterative CORDIC in vectoring mode. Converts a signed
// (x_in, y_in) pair into a gain-scaled magnitude and an angle in pi/256 units.
// A pre-rotation folds the left half-plane into the right half-plane. After
// that, eight micro-rotations run at one per clock.
//
// Ports:
//   clock  - rising-edge clock for all state
//   reset  - synchronous, active-high reset
//   start  - begin a conversion (accepted only while idle)
//   x_in   - signed X coordinate, captured on the accepting edge
//   y_in   - signed Y coordinate, captured on the accepting edge
//   busy   - high while micro-rotations are in progress
//   done   - one-cycle pulse when mag/angle take new values
//   mag    - unsigned magnitude, scaled by CORDIC gain K (~1.6468)
//   angle  - signed angle, LSB = pi/256 rad, wraps modulo 512
module cordic_vector #(
  parameter int DW   = 9,
  parameter int ITER = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] y_in,
  output logic                 busy,
  output logic                 done,
  output logic        [DW:0]   mag,
  output logic signed [DW-1:0] angle
);

  localparam int CW = $clog2(ITER);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic signed [DW+1:0] x, y, xe, ye, x_pre, y_pre, x_it, y_it, xs, ys;
  logic signed [DW:0]   z, z_pre, z_it, atan;
  logic        [CW-1:0] cnt;
  logic                 last;
  logic                 zero;

  assign busy = (state == RUN);
  assign last = (state == RUN) && (cnt == CW'(ITER - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Quadrant pre-rotation. The inputs are widened first so that negating the
  // most negative input value stays representable.
  always_comb begin
    xe = {{2{x_in[DW-1]}}, x_in};
    ye = {{2{y_in[DW-1]}}, y_in};
    if (!x_in[DW-1]) begin
      x_pre = xe;
      y_pre = ye;
      z_pre = '0;
    end else if (!y_in[DW-1]) begin
      x_pre = ye;
      y_pre = -xe;
      z_pre = (DW+1)'(128);
    end else begin
      x_pre = -ye;
      y_pre = xe;
      z_pre = -((DW+1)'(128));
    end
  end

  always_comb begin
    case (cnt)
      3'd0:    atan = (DW+1)'(64);
      3'd1:    atan = (DW+1)'(38);
      3'd2:    atan = (DW+1)'(20);
      3'd3:    atan = (DW+1)'(10);
      3'd4:    atan = (DW+1)'(5);
      3'd5:    atan = (DW+1)'(3);
      default: atan = (DW+1)'(1);
    endcase
  end

  always_comb begin
    xs = x >>> cnt;
    ys = y >>> cnt;
    if (!y[DW+1]) begin
      x_it = x + ys;
      y_it = y - xs;
      z_it = z + atan;
    end else begin
      x_it = x - ys;
      y_it = y + xs;
      z_it = z - atan;
    end
  end

  // The final micro-rotation and the result update share one edge. The
  // outputs are therefore loaded from the iteration result, not from the
  // registers. A zero input vector would otherwise accumulate every table
  // entry into z, so its angle is forced to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      zero  <= 1'b0;
      done  <= 1'b0;
      mag   <= '0;
      angle <= '0;
    end else begin
      state <= state_next;
      done  <= last;
      case (state)
        IDLE: begin
          if (start) begin
            x    <= x_pre;
            y    <= y_pre;
            z    <= z_pre;
            cnt  <= '0;
            zero <= (x_in == '0) && (y_in == '0);
          end
        end
        RUN: begin
          x   <= x_it;
          y   <= y_it;
          z   <= z_it;
          cnt <= cnt + CW'(1);
          if (last) begin
            mag   <= x_it[DW:0];
            angle <= zero ? '0 : z_it[DW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
module tb_cordic_vector;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [8:0] x_in  = '0;
  logic signed [8:0] y_in  = '0;
  logic              busy, done;
  logic        [9:0] mag;
  logic signed [8:0] angle;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vector #(.DW(9), .ITER(8)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .busy  (busy),
    .done  (done),
    .mag   (mag),
    .angle (angle)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: quadrant fold, then eight shift-add rotations on plain integers.
  function automatic void ref_cordic(input int xi, input int yi, output int m, output int a);
    int atab [8];
    int x, y, z, xn, yn;
    atab = '{64, 38, 20, 10, 5, 3, 1, 1};
    if (xi == 0 && yi == 0) begin
      m = 0;
      a = 0;
      return;
    end
    if (xi >= 0)      begin x = xi;  y = yi;  z = 0;    end
    else if (yi >= 0) begin x = yi;  y = -xi; z = 128;  end
    else              begin x = -yi; y = xi;  z = -128; end
    for (int i = 0; i < 8; i++) begin
      if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + atab[i]; end
      else        begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - atab[i]; end
      x = xn;
      y = yn;
    end
    m = x % 1024;
    a = (((z + 256) % 512) + 512) % 512 - 256;
  endfunction

  function automatic int f_mag(input int xi, input int yi);
    int m, a;
    ref_cordic(xi, yi, m, a);
    return m;
  endfunction

  function automatic int f_ang(input int xi, input int yi);
    int m, a;
    ref_cordic(xi, yi, m, a);
    return a;
  endfunction

  // Cycle-level expectation: idle/busy with a countdown to the result edge.
  bit m_valid = 1'b0;
  bit m_busy  = 1'b0;
  bit m_done  = 1'b0;
  int m_mag = 0, m_ang = 0, m_left = 0, p_mag = 0, p_ang = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_mag   <= 0;
      m_ang   <= 0;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_mag  <= p_mag;
          m_ang  <= p_ang;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= 8;
        p_mag  <= f_mag(int'(x_in), int'(y_in));
        p_ang  <= f_ang(int'(x_in), int'(y_in));
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("busy",  int'(busy),  int'(m_busy));
      check("done",  int'(done),  int'(m_done));
      check("mag",   int'(mag),   m_mag);
      check("angle", int'(angle), m_ang);
    end
  end

  task automatic conv(input int xi, input int yi, output int lat, output int dm, output int da);
    @(negedge clock);
    start = 1'b1;
    x_in  = 9'(xi);
    y_in  = 9'(yi);
    @(negedge clock);
    start = 1'b0;
    x_in  = 9'($urandom);
    y_in  = 9'($urandom);
    lat = 0;
    while (lat < 20 && !done) begin
      @(negedge clock);
      lat++;
    end
    dm = int'(mag);
    da = int'(angle);
  endtask

  int lat, dm, da, nd, gap, exp_m, exp_a;

  initial begin
    // Hand-computed pins for the reference itself.
    check("pin_m_100_0",   f_mag(100, 0),  166);
    check("pin_a_100_0",   f_ang(100, 0),  0);
    check("pin_m_m256_0",  f_mag(-256, 0), 424);
    check("pin_a_m256_0",  f_ang(-256, 0), -256);
    check("pin_a_0_0",     f_ang(0, 0),    0);

    repeat (3) @(negedge clock);
    check("rst_busy",  int'(busy),  0);
    check("rst_mag",   int'(mag),   0);
    check("rst_angle", int'(angle), 0);
    reset = 1'b0;

    conv(100, 0, lat, dm, da);
    check("lat_100_0", lat, 8);
    check_range("mag_100_0", dm, 163, 166);
    check_range("ang_100_0", da, -2, 2);

    conv(0, 100, lat, dm, da);
    check("lat_0_100", lat, 8);
    check_range("mag_0_100", dm, 163, 166);
    check_range("ang_0_100", da, 126, 130);

    conv(-100, -100, lat, dm, da);
    check_range("mag_m100_m100", dm, 230, 236);
    check_range("ang_m100_m100", da, -194, -190);

    conv(-256, 0, lat, dm, da);
    check_range("mag_m256_0", dm, 419, 424);
    check("ang_m256_0_wrap", int'(da >= 254 || da <= -254), 1);

    conv(0, 0, lat, dm, da);
    check("lat_zero", lat, 8);
    check("mag_zero", dm, 0);
    check("ang_zero", da, 0);

    // A start pulse during the run is ignored.
    @(negedge clock); start = 1'b1; x_in = 9'(50); y_in = -9'(30);
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    start = 1'b1; x_in = -9'(200); y_in = 9'(99);
    @(negedge clock); start = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        dm = int'(mag);
        da = int'(angle);
      end
    end
    check("ignore_ndone", nd, 1);
    check("ignore_mag", dm, f_mag(50, -30));
    check("ignore_ang", da, f_ang(50, -30));

    // Start held through the done cycle gives back-to-back conversions.
    @(negedge clock); start = 1'b1; x_in = 9'(30); y_in = -9'(70);
    gap = 0;
    while (gap < 20 && !done) begin @(negedge clock); gap++; end
    x_in = -9'(120); y_in = 9'(45);
    gap = 0;
    while (gap < 20) begin
      @(negedge clock);
      gap++;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_gap", gap, 9);
    check("b2b_mag", int'(mag), f_mag(-120, 45));
    check("b2b_ang", int'(angle), f_ang(-120, 45));
    repeat (12) @(negedge clock);

    // Reset during iteration 4 aborts without a done pulse.
    @(negedge clock); start = 1'b1; x_in = 9'(100); y_in = 9'(0);
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy",  int'(busy),  0);
    check("abort_done",  int'(done),  0);
    check("abort_mag",   int'(mag),   0);
    check("abort_angle", int'(angle), 0);
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("abort_ndone", nd, 0);
    conv(100, 0, lat, dm, da);
    check("post_lat", lat, 8);
    check_range("post_mag", dm, 163, 166);
    check_range("post_ang", da, -2, 2);

    // Randomised traffic, including corner operands and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       begin x_in = '0;          y_in = '0;          end
        1:       begin x_in = -9'(256);    y_in = 9'($urandom); end
        2:       begin x_in = 9'($urandom); y_in = -9'(256);   end
        default: begin x_in = 9'($urandom); y_in = 9'($urandom); end
      endcase
      reset = ($urandom_range(0, 299) == 0);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clock);

    // Expected values carried forward from the directed run.
    exp_m = f_mag(-100, -100);
    exp_a = f_ang(-100, -100);
    check_range("pin_m_m100", exp_m, 230, 236);
    check_range("pin_a_m100", exp_a, -194, -190);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
